// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one clocked 16-bit ALU between two valid/ready requesters.
// Optional statistics counters are enabled with ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_opcode,
    input  logic [15:0]       req0_a,
    input  logic [15:0]       req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_opcode,
    input  logic [15:0]       req1_a,
    input  logic [15:0]       req1_b,
    output logic [15:0]       alu_input1,
    output logic [15:0]       alu_input2,
    output logic [3:0]        alu_opcode,
    input  logic [31:0]       alu_result,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [31:0]       rsp_result,
    output logic              rsp_carry,
    output logic              rsp_err
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_ops0,
    output logic [CNT_W-1:0]  stat_ops1,
    output logic [CNT_W-1:0]  stat_err
`endif
);

    localparam logic [3:0] OP_DIV = 4'b1000;
    localparam logic [3:0] LAT_C  = 4'(ALU_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    if (ALU_LATENCY < 1 || ALU_LATENCY > 15 || CNT_W < 1) begin : g_param_range_invalid
        $error("alu_arbiter: ALU_LATENCY must be 1..15 and CNT_W >= 1");
    end

    state_t      state_r;
    logic        last_grant_r;
    logic [3:0]  wait_cnt_r;

    logic        grant_valid_s;
    logic        grant_id_s;
    logic [3:0]  sel_opcode_s;
    logic [15:0] sel_a_s;
    logic [15:0] sel_b_s;
    logic        div_zero_s;

    function automatic logic is_div_zero(input logic [3:0] opcode, input logic [15:0] b);
        return (opcode == OP_DIV) && (b == 16'h0000);
    endfunction

    // Grant selection: only in IDLE, round-robin on a tie, suppressed while in reset
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (state_r == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = ~last_grant_r;
            end else if (req0_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b0;
            end else if (req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b1;
            end else begin
                grant_valid_s = 1'b0;
                grant_id_s    = 1'b0;
            end
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // Payload of the granted requester and divide-by-zero detection
    always_comb begin
        sel_opcode_s = req0_opcode;
        sel_a_s      = req0_a;
        sel_b_s      = req0_b;
        if (grant_id_s) begin
            sel_opcode_s = req1_opcode;
            sel_a_s      = req1_a;
            sel_b_s      = req1_b;
        end else begin
            sel_opcode_s = req0_opcode;
            sel_a_s      = req0_a;
            sel_b_s      = req0_b;
        end
        div_zero_s = is_div_zero(sel_opcode_s, sel_b_s);
    end

    assign req0_ready = grant_valid_s & ~grant_id_s;
    assign req1_ready = grant_valid_s &  grant_id_s;

    // Arbiter FSM with registered ALU drive and response channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            wait_cnt_r   <= 4'd0;
            alu_input1   <= 16'h0000;
            alu_input2   <= 16'h0000;
            alu_opcode   <= 4'h0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= 32'h0000_0000;
            rsp_carry    <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        rsp_id       <= grant_id_s;
                        last_grant_r <= grant_id_s;
                        if (div_zero_s) begin
                            // Answered locally; the ALU never sees this operation
                            rsp_result <= 32'h0000_0000;
                            rsp_carry  <= 1'b0;
                            rsp_err    <= 1'b1;
                            rsp_valid  <= 1'b1;
                            state_r    <= RESP;
                        end else begin
                            alu_input1 <= sel_a_s;
                            alu_input2 <= sel_b_s;
                            alu_opcode <= sel_opcode_s;
                            wait_cnt_r <= LAT_C;
                            state_r    <= EXEC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    // Counter covers the ALU sampling edge plus ALU_LATENCY result edges
                    if (wait_cnt_r == 4'd0) begin
                        rsp_result <= alu_result;
                        rsp_carry  <= alu_carry;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state_r    <= RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r   <= RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Per-requester grant counters and divide-by-zero interception counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops0 <= '0;
            stat_ops1 <= '0;
            stat_err  <= '0;
        end else begin
            if (grant_valid_s && !grant_id_s) begin
                stat_ops0 <= stat_ops0 + CNT_W'(1);
            end else begin
                stat_ops0 <= stat_ops0;
            end
            if (grant_valid_s && grant_id_s) begin
                stat_ops1 <= stat_ops1 + CNT_W'(1);
            end else begin
                stat_ops1 <= stat_ops1;
            end
            if (grant_valid_s && div_zero_s) begin
                stat_err <= stat_err + CNT_W'(1);
            end else begin
                stat_err <= stat_err;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table vectors, directed corner sequences,
// randomized traffic against a scoreboard and a behavioural ALU with clocked latency.
module tb_alu_arbiter;

    localparam int LAT = 1;
    localparam int CW  = 16;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_opcode, req1_opcode, alu_opcode;
    logic [15:0] req0_a, req0_b, req1_a, req1_b, alu_input1, alu_input2;
    logic [31:0] alu_result, rsp_result;
    logic        alu_carry, rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
`ifdef ALU_ARB_STATS_EN
    logic [CW-1:0] stat_ops0, stat_ops1, stat_err;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(.ALU_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
`ifdef ALU_ARB_STATS_EN
        , .stat_ops0(stat_ops0), .stat_ops1(stat_ops1), .stat_err(stat_err)
`endif
    );

    // Behavioural ALU: {carry, result}
    function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        case (op)
            OP_ADD: begin w = {1'b0, a} + {1'b0, b}; return {w[16], 16'h0000, w[15:0]}; end
            OP_SUB: begin w = {1'b0, a} - {1'b0, b}; return {w[16], 16'h0000, w[15:0]}; end
            OP_MUL: return {1'b0, {16'h0000, a} * {16'h0000, b}};
            OP_DIV: begin
                if (b == 16'h0000) return {1'b1, 32'hDEAD_BEEF};
                else return {1'b0, 16'h0000, a / b};
            end
            default: return {1'b0, a, b};
        endcase
    endfunction

    logic [32:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= alu_ref(alu_opcode, alu_input1, alu_input2);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_carry  = pipe[LAT-1][32];
    assign alu_result = pipe[LAT-1][31:0];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected responses in acceptance order, with grant cycle for latency
    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        carry;
        logic        err;
        int          gcyc;
    } exp_t;

    exp_t  sb [$];
    logic  glog [$];
    int    cyc = 0;
    logic  mdl_last = 1'b1;
    logic  seen = 1'b0;
    logic [34:0] held;
    int    n_g0 = 0, n_g1 = 0, n_dz = 0;

    always @(negedge clk) begin
        exp_t        e;
        logic        gid;
        logic [3:0]  op;
        logic [15:0] a, b;
        logic [32:0] r;
        logic [34:0] cur;
        cyc++;
        if (rst) begin
            sb.delete();
            glog.delete();
            mdl_last = 1'b1;
            seen = 1'b0;
            n_g0 = 0; n_g1 = 0; n_dz = 0;
        end else begin
            chk("ready_exclusive", {63'd0, req0_ready & req1_ready}, 64'd0);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                gid = req1_ready;
                if (req0_valid && req1_valid) chk("rr_order", {63'd0, gid}, {63'd0, ~mdl_last});
                mdl_last = gid;
                glog.push_back(gid);
                op = gid ? req1_opcode : req0_opcode;
                a  = gid ? req1_a : req0_a;
                b  = gid ? req1_b : req0_b;
                e.id = gid;
                e.gcyc = cyc;
                if (op == OP_DIV && b == 16'h0000) begin
                    e.res = 32'h0; e.carry = 1'b0; e.err = 1'b1; n_dz++;
                end else begin
                    r = alu_ref(op, a, b);
                    e.res = r[31:0]; e.carry = r[32]; e.err = 1'b0;
                end
                if (gid) n_g1++; else n_g0++;
                sb.push_back(e);
            end
            if (rsp_valid) begin
                cur = {rsp_id, rsp_result, rsp_carry, rsp_err};
                if (!seen) begin
                    chk("rsp_expected", {63'd0, sb.size() != 0}, 64'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("rsp_fields", {29'd0, cur}, {29'd0, e.id, e.res, e.carry, e.err});
                        chk("rsp_latency", 64'(cyc - e.gcyc), e.err ? 64'd1 : 64'(LAT + 2));
                    end
                    held = cur;
                    seen = 1'b1;
                end else begin
                    chk("rsp_stable", {29'd0, cur}, {29'd0, held});
                end
                if (rsp_ready) seen = 1'b0;
            end
        end
    end

    task automatic issue(input logic id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int t = 0;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b; end
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && t < 200) begin @(negedge clk); t++; end
        chk("issue_timeout", {63'd0, t >= 200}, 64'd0);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic id, output logic [31:0] res, output logic car, output logic err);
        int t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
        chk("rsp_timeout", {63'd0, t >= 100}, 64'd0);
        id = rsp_id; res = rsp_result; car = rsp_carry; err = rsp_err;
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        while ((sb.size() != 0 || rsp_valid) && t < 500) begin @(negedge clk); t++; end
        chk("drain_timeout", {63'd0, t >= 500}, 64'd0);
    endtask

    task automatic rand_driver(input logic id, input int n);
        logic [15:0] b;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            b = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                // brief valid pulse that may or may not be granted
                @(posedge clk); #1;
                if (id) begin req1_valid = 1'b1; req1_opcode = OP_ADD; req1_a = 16'($urandom); req1_b = b; end
                else    begin req0_valid = 1'b1; req0_opcode = OP_ADD; req0_a = 16'($urandom); req0_b = b; end
                @(posedge clk); #1;
                if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
            end else begin
                case ($urandom_range(0, 3))
                    0: issue(id, OP_ADD, 16'($urandom), b);
                    1: issue(id, OP_SUB, 16'($urandom), b);
                    2: issue(id, OP_MUL, 16'($urandom), b);
                    default: issue(id, OP_DIV, 16'($urandom), b);
                endcase
            end
        end
    endtask

    typedef struct {
        logic        id;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] res;
        logic        carry;
        logic        err;
    } vec_t;

    vec_t        vt [8];
    logic        r_id, r_car, r_err;
    logic [31:0] r_res;
    int          gbase;
    logic        rand_done;

    initial begin
        vt[0] = '{1'b0, OP_ADD, 16'h0003, 16'h0005, 32'h0000_0008, 1'b0, 1'b0};
        vt[1] = '{1'b1, OP_ADD, 16'hFFFF, 16'h0001, 32'h0000_0000, 1'b1, 1'b0};
        vt[2] = '{1'b0, OP_SUB, 16'h0005, 16'h0003, 32'h0000_0002, 1'b0, 1'b0};
        vt[3] = '{1'b1, OP_SUB, 16'h0003, 16'h0005, 32'h0000_FFFE, 1'b1, 1'b0};
        vt[4] = '{1'b0, OP_MUL, 16'h1234, 16'h0100, 32'h0012_3400, 1'b0, 1'b0};
        vt[5] = '{1'b1, OP_DIV, 16'h0010, 16'h0003, 32'h0000_0005, 1'b0, 1'b0};
        vt[6] = '{1'b0, OP_DIV, 16'h0010, 16'h0000, 32'h0000_0000, 1'b0, 1'b1};
        vt[7] = '{1'b1, OP_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 1'b0};

        req0_valid = 1'b1; req0_opcode = 4'h0; req0_a = 16'h0; req0_b = 16'h0;
        req1_valid = 1'b0; req1_opcode = 4'h0; req1_a = 16'h0; req1_b = 16'h0;
        rsp_ready = 1'b1;
        rand_done = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {8'd0, rsp_valid, rsp_id, rsp_carry, rsp_err, alu_opcode, alu_input1, alu_input2}, 64'd0);
        chk("reset_result", {32'd0, rsp_result}, 64'd0);
        chk("reset_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven single operations
        for (int i = 0; i < 8; i++) begin
            issue(vt[i].id, vt[i].op, vt[i].a, vt[i].b);
            wait_rsp(r_id, r_res, r_car, r_err);
            chk($sformatf("vec%0d_id", i), {63'd0, r_id}, {63'd0, vt[i].id});
            chk($sformatf("vec%0d_result", i), {32'd0, r_res}, {32'd0, vt[i].res});
            chk($sformatf("vec%0d_flags", i), {62'd0, r_car, r_err}, {62'd0, vt[i].carry, vt[i].err});
        end
        drain();

        // Both requesters contending: grants must alternate starting with req0
        gbase = glog.size();
        fork
            for (int k = 0; k < 3; k++) issue(1'b0, OP_MUL, 16'h0002, 16'h0003);
            for (int k = 0; k < 3; k++) issue(1'b1, OP_MUL, 16'h0002, 16'h0003);
        join
        drain();
        chk("tie_grant_count", 64'(glog.size() - gbase), 64'd6);
        for (int k = 0; k < 6; k++) begin
            if (gbase + k < glog.size())
                chk($sformatf("tie_grant%0d", k), {63'd0, glog[gbase + k]}, 64'(k % 2));
        end

        // Divide-by-zero leaves the ALU drive untouched
        issue(1'b0, OP_DIV, 16'h0010, 16'h0000);
        wait_rsp(r_id, r_res, r_car, r_err);
        chk("dz_rsp", {30'd0, r_res, r_car, r_err}, 64'd1);
        chk("dz_alu_hold", {28'd0, alu_opcode, alu_input1, alu_input2}, {28'd0, OP_MUL, 16'h0002, 16'h0003});
`ifdef ALU_ARB_STATS_EN
        chk("dz_stat_err", {48'd0, stat_err}, 64'(n_dz));
`endif
        drain();

        // Response back-pressure: held response, no grant until accepted
        rsp_ready = 1'b0;
        issue(1'b0, OP_ADD, 16'h0001, 16'h0002);
        wait_rsp(r_id, r_res, r_car, r_err);
        gbase = glog.size();
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_opcode = OP_ADD; req1_a = 16'h0007; req1_b = 16'h0007;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold", {29'd0, rsp_valid, req1_ready, rsp_result}, {29'd0, 1'b1, 1'b0, 32'h0000_0003});
        end
        chk("bp_no_grant", 64'(glog.size() - gbase), 64'd0);
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        issue(1'b1, OP_ADD, 16'h0007, 16'h0007);
        drain();
        chk("bp_one_grant", 64'(glog.size() - gbase), 64'd1);

        // Randomized traffic from both requesters with random back-pressure
        fork
            begin
                fork
                    rand_driver(1'b0, 60);
                    rand_driver(1'b1, 60);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drain();
`ifdef ALU_ARB_STATS_EN
        chk("stat_ops0", {48'd0, stat_ops0}, 64'(16'(n_g0)));
        chk("stat_ops1", {48'd0, stat_ops1}, 64'(16'(n_g1)));
        chk("stat_err", {48'd0, stat_err}, 64'(16'(n_dz)));
`endif

        // Reset during EXEC discards the operation; next tie goes to req0
        issue(1'b0, OP_SUB, 16'h0009, 16'h0004);
        #1;
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst_async_alu", {28'd0, alu_opcode, alu_input1, alu_input2}, 64'd0);
        chk("rst_async_rsp", {29'd0, rsp_valid, rsp_id, rsp_carry, rsp_err, rsp_result}, 64'd0);
        chk("rst_async_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
`ifdef ALU_ARB_STATS_EN
        chk("rst_stats", {16'd0, stat_ops0, stat_ops1, stat_err}, 64'd0);
`endif
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        fork
            issue(1'b0, OP_ADD, 16'h0001, 16'h0001);
            issue(1'b1, OP_ADD, 16'h0002, 16'h0002);
        join
        drain();
        chk("rst_tie_count", 64'(glog.size()), 64'd2);
        if (glog.size() != 0) chk("rst_tie_first", {63'd0, glog[0]}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
